regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (RegWrite/Rd/Write_data) between two writeback requesters: requester 0 is the ALU path, requester 1 is the load/multi-cycle path.
- Arbitration is round-robin with valid/ready handshakes.
- The write port is driven from a registered output stage.
- A 32-entry pending-destination scoreboard lets the decode stage stall on register hazards.
- Sits between the execute/memory units and the register file.

---
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a registered
// write stage and a pending-destination scoreboard used by decode for hazard stalls.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [4:0]      req0_rd,
  input  logic [XLEN-1:0] req0_data,
  input  logic [4:0]      req1_rd,
  input  logic [XLEN-1:0] req1_data,
  input  logic            alloc_valid,
  input  logic [4:0]      alloc_rd,
  output logic            alloc_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            flush,
  output logic            wr_en,
  output logic [4:0]      wr_rd,
  output logic [XLEN-1:0] wr_data
);

  localparam logic [NREGS-1:0] BIT0 = {{(NREGS-1){1'b0}}, 1'b1};

  logic [1:0]       grant_s;
  logic             xfer_s;
  logic [4:0]       sel_rd_s;
  logic [XLEN-1:0]  sel_data_s;
  logic             last_grant_r;
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;
  logic             alloc_fire_s;

  // Grant selection: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_s = 2'b00;
    if (flush) begin
      grant_s = 2'b00;
    end else begin
      case (req_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = last_grant_r ? 2'b01 : 2'b10;
        default: grant_s = 2'b00;
      endcase
    end
  end

  assign req_ready = grant_s;
  assign xfer_s    = |(req_valid & grant_s);

  // Mux the granted requester's destination and data toward the output stage.
  always_comb begin
    sel_rd_s   = req0_rd;
    sel_data_s = req0_data;
    if (grant_s[1]) begin
      sel_rd_s   = req1_rd;
      sel_data_s = req1_data;
    end else begin
      sel_rd_s   = req0_rd;
      sel_data_s = req0_data;
    end
  end

  // Priority pointer: remembers the requester of the most recent transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r <= 1'b1;
    end else if (xfer_s) begin
      last_grant_r <= grant_s[1];
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Registered write port; an x0 transfer updates rd/data but never raises wr_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_rd   <= 5'd0;
      wr_data <= {XLEN{1'b0}};
    end else if (xfer_s) begin
      wr_en   <= (sel_rd_s != 5'd0);
      wr_rd   <= sel_rd_s;
      wr_data <= sel_data_s;
    end else begin
      wr_en   <= 1'b0;
      wr_rd   <= wr_rd;
      wr_data <= wr_data;
    end
  end

  // Only one outstanding writer per register, so a flop vector is enough.
  assign alloc_ready  = ~busy_r[alloc_rd] | (alloc_rd == 5'd0);
  assign alloc_fire_s = alloc_valid & alloc_ready & ~flush & (alloc_rd != 5'd0);
  assign set_mask_s   = alloc_fire_s ? (BIT0 << alloc_rd) : {NREGS{1'b0}};
  assign clr_mask_s   = wr_en ? (BIT0 << wr_rd) : {NREGS{1'b0}};

  // Set is applied after clear so a same-index allocation survives its predecessor's write.
  always_comb begin
    busy_nxt_s = busy_r;
    if (flush) begin
      busy_nxt_s = {NREGS{1'b0}};
    end else begin
      busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign rs1_busy = (rs1 != 5'd0) & busy_r[rs1];
  assign rs2_busy = (rs2 != 5'd0) & busy_r[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes are queued at issue time and
// a negedge monitor compares them against the register-file write port.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        flush;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  regfile_wb_arbiter #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_rd(req1_rd), .req1_data(req1_data),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .flush(flush),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Write-port monitor: every wr_en must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && wr_en) begin
      if (exp_q.size() == 0) begin
        check("spurious_wr_en", {63'd0, wr_en}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_rd", {59'd0, wr_rd}, {59'd0, e.rd});
        check("wr_data", {32'd0, wr_data}, {32'd0, e.data});
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; req0_rd = 5'd0; req0_data = 32'd0; req1_rd = 5'd0; req1_data = 32'd0;
    alloc_valid = 1'b0; alloc_rd = 5'd0; rs1 = 5'd7; rs2 = 5'd9; flush = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_wr_rd", {59'd0, wr_rd}, 64'd0);
    check("rst_wr_data", {32'd0, wr_data}, 64'd0);
    check("rst_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    check("rst_rs2_busy", {63'd0, rs2_busy}, 64'd0);
    check("rst_req_ready", {62'd0, req_ready}, 64'd0);
    rst = 1'b1;

    // Contention from reset: 01,10,01,10 and writes 3,4,3,4
    req0_rd = 5'd3; req0_data = 32'hAAAA_0003;
    req1_rd = 5'd4; req1_data = 32'hBBBB_0004;
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b11;
      mid();
      check("contend_grant", {62'd0, req_ready}, (i % 2 == 0) ? 64'd1 : 64'd2);
      if (i % 2 == 0) push(5'd3, 32'hAAAA_0003);
      else            push(5'd4, 32'hBBBB_0004);
      nxt();
    end

    // Single requester
    req_valid = 2'b01; req0_rd = 5'd5; req0_data = 32'hDEAD_BEEF;
    mid();
    check("single_grant", {62'd0, req_ready}, 64'd1);
    push(5'd5, 32'hDEAD_BEEF);
    nxt();
    req_valid = 2'b00;
    mid();
    check("single_wr_en_t1", {63'd0, wr_en}, 64'd1);
    nxt();
    mid();
    check("single_wr_en_t2", {63'd0, wr_en}, 64'd0);
    nxt();

    // Scoreboard on rd=7
    alloc_valid = 1'b1; alloc_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd0;
    mid();
    check("sb_alloc_ready1", {63'd0, alloc_ready}, 64'd1);
    check("sb_rs1_busy_pre", {63'd0, rs1_busy}, 64'd0);
    nxt();
    mid();
    check("sb_alloc_ready2", {63'd0, alloc_ready}, 64'd0);
    check("sb_rs1_busy_set", {63'd0, rs1_busy}, 64'd1);
    nxt();
    alloc_valid = 1'b0; req_valid = 2'b10; req1_rd = 5'd7; req1_data = 32'h0000_0777;
    mid();
    check("sb_grant1", {62'd0, req_ready}, 64'd2);
    push(5'd7, 32'h0000_0777);
    nxt();
    req_valid = 2'b00;
    mid();
    check("sb_rs1_busy_wr", {63'd0, rs1_busy}, 64'd1);
    nxt();
    mid();
    check("sb_rs1_busy_clr", {63'd0, rs1_busy}, 64'd0);
    check("sb_alloc_ready3", {63'd0, alloc_ready}, 64'd1);
    nxt();

    // x0: allocation and transfers with rd=0 never write but do rotate
    alloc_valid = 1'b1; alloc_rd = 5'd0; rs1 = 5'd0;
    mid();
    check("x0_alloc_ready", {63'd0, alloc_ready}, 64'd1);
    nxt();
    alloc_valid = 1'b0; req_valid = 2'b01; req0_rd = 5'd0; req0_data = 32'h1234_5678;
    req1_rd = 5'd0; req1_data = 32'h8765_4321;
    mid();
    check("x0_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    check("x0_grant0", {62'd0, req_ready}, 64'd1);
    nxt();
    req_valid = 2'b11;
    mid();
    check("x0_rotate1", {62'd0, req_ready}, 64'd2);
    nxt();
    mid();
    check("x0_rotate2", {62'd0, req_ready}, 64'd1);
    nxt();
    req_valid = 2'b00;
    mid();
    check("x0_wr_en", {63'd0, wr_en}, 64'd0);
    nxt();

    // Flush with busy[9]=1 and a write in flight
    alloc_valid = 1'b1; alloc_rd = 5'd9; rs2 = 5'd9;
    req_valid = 2'b01; req0_rd = 5'd10; req0_data = 32'hA5A5_0010;
    mid();
    check("fl_pre_grant", {62'd0, req_ready}, 64'd1);
    push(5'd10, 32'hA5A5_0010);
    nxt();
    alloc_rd = 5'd12; rs1 = 5'd12; flush = 1'b1;
    req_valid = 2'b11; req0_rd = 5'd1; req1_rd = 5'd2;
    mid();
    check("fl_ready", {62'd0, req_ready}, 64'd0);
    check("fl_rs2_busy", {63'd0, rs2_busy}, 64'd1);
    check("fl_wr_in_flight", {63'd0, wr_en}, 64'd1);
    nxt();
    flush = 1'b0; alloc_valid = 1'b0; req_valid = 2'b00;
    mid();
    check("fl_busy9_clr", {63'd0, rs2_busy}, 64'd0);
    check("fl_no_alloc", {63'd0, rs1_busy}, 64'd0);
    nxt();

    // Same-index set and clear: set wins
    req_valid = 2'b10; req1_rd = 5'd9; req1_data = 32'h9999_0009;
    mid();
    check("sc_grant", {62'd0, req_ready}, 64'd2);
    push(5'd9, 32'h9999_0009);
    nxt();
    req_valid = 2'b00; alloc_valid = 1'b1; alloc_rd = 5'd9;
    mid();
    check("sc_wr_en", {63'd0, wr_en}, 64'd1);
    check("sc_alloc_ready", {63'd0, alloc_ready}, 64'd1);
    nxt();
    alloc_valid = 1'b0; rs1 = 5'd9;
    mid();
    check("sc_busy9", {63'd0, rs1_busy}, 64'd1);
    check("sc_alloc_blocked", {63'd0, alloc_ready}, 64'd0);
    nxt();

    // Reset mid-operation drops the pending write and clears all state
    req_valid = 2'b01; req0_rd = 5'd11; req0_data = 32'h0BAD_F00D;
    alloc_valid = 1'b1; alloc_rd = 5'd13;
    mid();
    check("mr_grant", {62'd0, req_ready}, 64'd1);
    push(5'd11, 32'h0BAD_F00D);
    nxt();
    req_valid = 2'b00; alloc_valid = 1'b0; rs2 = 5'd13;
    #1;
    check("mr_busy13_pre", {63'd0, rs2_busy}, 64'd1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mr_wr_en", {63'd0, wr_en}, 64'd0);
    check("mr_wr_rd", {59'd0, wr_rd}, 64'd0);
    check("mr_wr_data", {32'd0, wr_data}, 64'd0);
    check("mr_busy13", {63'd0, rs2_busy}, 64'd0);
    check("mr_busy9", {63'd0, rs1_busy}, 64'd0);
    nxt();
    rst = 1'b1;
    req_valid = 2'b11; req0_rd = 5'd14; req0_data = 32'h0000_0E0E;
    req1_rd = 5'd15; req1_data = 32'h0000_0F0F;
    mid();
    check("mr_last_grant", {62'd0, req_ready}, 64'd1);
    push(5'd14, 32'h0000_0E0E);
    nxt();
    req_valid = 2'b00;
    nxt();
    mid();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
